// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/DMA memory arbiter.
// The ROM map constant also drives the optional MEM_ARB_ROM_WP_EN guard.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam logic [15:0] ROM_BASE_DEF = 16'hF000;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    DMA
  } grant_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating starvation counter for a pending DMA request.
// at_max tells the arbiter the DMA port must win this edge.
module mem_arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [7:0] cnt;

  assign at_max = (cnt >= 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU priority, DMA anti-starvation.
// Define MEM_ARB_ROM_WP_EN to suppress writes at or above ROM_BASE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = 4,
  parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(ROM_BASE_DEF)
) (
  input  logic              ph2,
  input  logic              reset_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wp_err
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  grant_t      state_q;
  grant_t      state_d;
  port_req_t   cpu_r;
  port_req_t   dma_r;
  port_req_t   sel;
  logic        at_max;
  logic        cpu_win;
  logic        dma_win;
  logic        blk;
  logic        req_we_q;
  logic        cpu_rv_q;
  logic        dma_rv_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] dma_rd_q;

  assign cpu_r = {cpu_we, cpu_addr, cpu_wdata};
  assign dma_r = {dma_we, dma_addr, dma_wdata};

  assign cpu_win = cpu_req && (!dma_req || !at_max);
  assign dma_win = dma_req && !cpu_win;

  mem_arb_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk   (ph2),
    .rst_n (reset_b),
    .inc   (dma_req && cpu_win),
    .clr   (dma_win || !dma_req),
    .at_max(at_max)
  );

  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      cpu_win: state_d = CPU;
      dma_win: state_d = DMA;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel = cpu_r;
    blk = 1'b0;
    if (state_d == DMA) sel = dma_r;
`ifdef MEM_ARB_ROM_WP_EN
    blk = (state_d != IDLE) && sel.we
          && (sel.addr >= ROM_BASE);
`endif
  end

  assign cpu_gnt = (state_q == CPU);
  assign dma_gnt = (state_q == DMA);
  assign mem_en  = (state_q != IDLE);

  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wp_err    <= 1'b0;
      req_we_q  <= 1'b0;
    end else begin
      mem_we   <= (state_d != IDLE) && sel.we && !blk;
      wp_err   <= blk;
      req_we_q <= sel.we;
      if (state_d != IDLE) begin
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
      end
    end
  end

  // rvalid covers the cycle mem_rdata is live; the hold
  // register keeps that value once rvalid drops.
  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      cpu_rv_q <= (state_q == CPU) && !req_we_q;
      dma_rv_q <= (state_q == DMA) && !req_we_q;
      if (cpu_rv_q) cpu_rd_q <= mem_rdata;
      if (dma_rv_q) dma_rd_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rv_q;
  assign dma_rvalid = dma_rv_q;
  assign cpu_rdata  = cpu_rv_q ? mem_rdata : cpu_rd_q;
  assign dma_rdata  = dma_rv_q ? mem_rdata : dma_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural sync memory.
// Expectations follow MEM_ARB_ROM_WP_EN when it is defined.
module tb_mem_arbiter;

  logic        ph2;
  logic        reset_b;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wp_err;

  logic [7:0] mem [0:65535];

  int n_chk;
  int n_err;

  mem_arbiter dut (
    .ph2       (ph2),
    .reset_b   (reset_b),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wp_err    (wp_err)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  always @(posedge ph2) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ph2);
    #1;
  endtask

  task automatic cpu_set(input logic r, input logic w,
                         input logic [15:0] a,
                         input logic [7:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input logic r, input logic w,
                         input logic [15:0] a,
                         input logic [7:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  logic wp_on;
  logic [7:0] rom_after;

  initial begin
    n_chk = 0;
    n_err = 0;
`ifdef MEM_ARB_ROM_WP_EN
    wp_on = 1'b1;
    rom_after = 8'h00;
`else
    wp_on = 1'b0;
    rom_after = 8'hAA;
`endif
    mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0003] = 8'h22;
    mem[16'h0123] = 8'h5A;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hF0;
    reset_b = 1'b0;
    cpu_set(0, 0, 16'h0, 8'h0);
    dma_set(0, 0, 16'h0, 8'h0);

    repeat (2) tick;
    chk("rst_ctl", {cpu_gnt, dma_gnt, mem_en, mem_we,
        wp_err, cpu_rvalid, dma_rvalid}, 0);
    chk("rst_data", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 0);
    reset_b = 1'b1;
    tick;
    chk("idle_en", mem_en, 0);

    // CPU read of 0x0003
    cpu_set(1, 0, 16'h0003, 8'h00);
    tick;
    chk("rd_gnt", {cpu_gnt, dma_gnt, mem_en, mem_we}, 4'b1010);
    chk("rd_addr", mem_addr, 16'h0003);
    cpu_set(0, 0, 16'h0, 8'h0);
    tick;
    chk("rd_rv", {cpu_gnt, dma_gnt, cpu_rvalid}, 3'b001);
    chk("rd_data", cpu_rdata, 8'h22);
    tick;
    chk("rd_hold", {cpu_rvalid, cpu_rdata}, {1'b0, 8'h22});

    // CPU write 0x75 to 0x0004, then back-to-back read
    cpu_set(1, 1, 16'h0004, 8'h75);
    tick;
    chk("wr_gnt", {cpu_gnt, mem_en, mem_we}, 3'b111);
    chk("wr_bus", {mem_addr, mem_wdata}, {16'h0004, 8'h75});
    cpu_set(1, 0, 16'h0004, 8'h00);
    tick;
    chk("wr_rd_gnt", {cpu_gnt, mem_we, cpu_rvalid}, 3'b100);
    cpu_set(0, 0, 16'h0, 8'h0);
    tick;
    chk("wr_rd_rv", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h75});
    tick;

    // Continuous contention: CPU x4 then DMA
    cpu_set(1, 0, 16'h0003, 8'h00);
    dma_set(1, 0, 16'hFFFD, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("cont%0d", i), {cpu_gnt, dma_gnt},
          (i % 5 == 4) ? 2'b01 : 2'b10);
    end
    cpu_set(0, 0, 16'h0, 8'h0);
    dma_set(0, 0, 16'h0, 8'h0);
    repeat (2) tick;

    // DMA back-to-back reads from the ROM region
    dma_set(1, 0, 16'hFFFC, 8'h00);
    tick;
    chk("dma0_gnt", {cpu_gnt, dma_gnt, mem_addr}, {2'b01, 16'hFFFC});
    dma_set(1, 0, 16'hFFFD, 8'h00);
    tick;
    chk("dma1_gnt", {dma_gnt, mem_addr}, {1'b1, 16'hFFFD});
    chk("dma0_rv", {dma_rvalid, dma_rdata}, {1'b1, 8'h00});
    dma_set(0, 0, 16'h0, 8'h0);
    tick;
    chk("dma1_rv", {dma_gnt, dma_rvalid, dma_rdata}, {2'b01, 8'hF0});
    tick;
    chk("dma_hold", {dma_rvalid, dma_rdata}, {1'b0, 8'hF0});

    // Writes to ROM and RAM through the DMA port
    dma_set(1, 1, 16'hF123, 8'hAA);
    tick;
    chk("wp_gnt", {dma_gnt, mem_en}, 2'b11);
    chk("wp_we", {mem_we, wp_err}, {~wp_on, wp_on});
    dma_set(1, 1, 16'h0123, 8'h00);
    tick;
    chk("ram_wr", {mem_we, wp_err, dma_rvalid, mem_addr},
        {3'b100, 16'h0123});
    dma_set(0, 0, 16'h0, 8'h0);
    tick;
    chk("ram_val", mem[16'h0123], 8'h00);
    chk("rom_val", mem[16'hF123], rom_after);
    chk("wr_norv", {dma_rvalid, wp_err, mem_en}, 0);

    // Reset between grant and rvalid
    cpu_set(1, 0, 16'h0003, 8'h00);
    tick;
    chk("mr_gnt", cpu_gnt, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("mr_ctl", {cpu_gnt, dma_gnt, mem_en, mem_we,
        wp_err, cpu_rvalid, dma_rvalid}, 0);
    chk("mr_data", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 0);
    tick;
    chk("mr_norv", {cpu_rvalid, cpu_gnt}, 0);
    @(negedge ph2);
    reset_b = 1'b1;
    tick;
    chk("mr_first", {cpu_gnt, cpu_rvalid}, 2'b10);
    cpu_set(0, 0, 16'h0, 8'h0);
    tick;
    chk("mr_rv", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h22});
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
